// File: rtl/mm_cdr_seq_ctrl_pkg.sv
// Shared types and helpers for the MM CDR acquisition/tracking sequencer.
// The state encoding is reused by debug logic and the bench.
package mm_cdr_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXT_HOLD = 3'd1,
    PROP_ACQ = 3'd2,
    FREQ_ACQ = 3'd3,
    TRACK    = 3'd4,
    LOCKED   = 3'd5
  } cdr_seq_state_t;

  function automatic logic use_trk_gains(cdr_seq_state_t s);
    return (s == TRACK) || (s == LOCKED);
  endfunction

  function automatic logic ext_pi_ctl_on(cdr_seq_state_t s);
    return (s == IDLE) || (s == EXT_HOLD);
  endfunction

  function automatic logic freq_est_on(cdr_seq_state_t s);
    return (s == FREQ_ACQ) || (s == TRACK) || (s == LOCKED);
  endfunction

endpackage

// File: rtl/mm_cdr_seq_ctrl_lock_det.sv
// Lock detector: |phase_error| against a threshold, with saturating run counters for
// consecutive in-lock and out-of-lock samples. lock_hit/lock_miss fire when a run reaches lock_len.
module mm_cdr_seq_ctrl_lock_det
  import mm_cdr_seq_ctrl_pkg::*;
#(
  parameter int unsigned Nadc      = 8,
  parameter int unsigned cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 ext_rstb,
  input  logic                 clr,
  input  logic [Nadc+1:0]      phase_error,
  input  logic [Nadc:0]        lock_thresh,
  input  logic [cnt_width-1:0] lock_len,
  output logic                 lock_hit,
  output logic                 lock_miss
);

  localparam logic [Nadc:0]        AbsOne = {{Nadc{1'b0}}, 1'b1};
  localparam logic [cnt_width-1:0] CntOne = {{(cnt_width-1){1'b0}}, 1'b1};

  logic [Nadc:0]        pe_abs;
  logic                 in_lock;
  logic [cnt_width-1:0] len_m1;
  logic [cnt_width-1:0] in_run_q, in_run_d;
  logic [cnt_width-1:0] out_run_q, out_run_d;

  // Low bits of the two's-complement negation are exact for every negative value except the
  // most-negative one, which is saturated to the largest magnitude instead of wrapping to 0.
  always_comb begin
    pe_abs = phase_error[Nadc:0];
    if (phase_error[Nadc+1]) begin
      if (phase_error[Nadc:0] == '0) begin
        pe_abs = '1;
      end else begin
        pe_abs = ~phase_error[Nadc:0] + AbsOne;
      end
    end
  end

  assign in_lock   = pe_abs < lock_thresh;
  assign len_m1    = (lock_len == '0) ? '0 : lock_len - CntOne;
  assign lock_hit  = in_lock && (in_run_q >= len_m1);
  assign lock_miss = !in_lock && (out_run_q >= len_m1);

  always_comb begin
    in_run_d  = '0;
    out_run_d = '0;
    if (!clr) begin
      if (in_lock) begin
        in_run_d = (in_run_q == '1) ? in_run_q : in_run_q + CntOne;
      end else begin
        out_run_d = (out_run_q == '1) ? out_run_q : out_run_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge ext_rstb) begin
    if (!ext_rstb) begin
      in_run_q  <= '0;
      out_run_q <= '0;
    end else begin
      in_run_q  <= in_run_d;
      out_run_q <= out_run_d;
    end
  end

endmodule

// File: rtl/mm_cdr_seq_ctrl.sv
// Acquisition/tracking sequencer for the 2nd-order MM CDR loop: steps from external PI control
// through acquisition gains to tracking gains, declares lock and re-acquires on lock loss.
module mm_cdr_seq_ctrl
  import mm_cdr_seq_ctrl_pkg::*;
#(
  parameter int unsigned Nadc       = 8,
  parameter int unsigned prop_width = 6,
  parameter int unsigned intg_width = 6,
  parameter int unsigned cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  ext_rstb,
  input  logic                  start,
  input  logic [Nadc+1:0]       phase_error,
  input  logic [prop_width-1:0] kp_acq,
  input  logic [prop_width-1:0] kp_trk,
  input  logic [intg_width-1:0] ki_acq,
  input  logic [intg_width-1:0] ki_trk,
  input  logic [cnt_width-1:0]  t_ext,
  input  logic [cnt_width-1:0]  t_prop,
  input  logic [cnt_width-1:0]  t_freq,
  input  logic [Nadc:0]         lock_thresh,
  input  logic [cnt_width-1:0]  lock_len,
  output logic [prop_width-1:0] Kp,
  output logic [intg_width-1:0] Ki,
  output logic                  en_ext_pi_ctl,
  output logic                  en_freq_est,
  output logic                  locked,
  output logic                  lock_lost,
  output logic [2:0]            seq_state
);

  localparam logic [cnt_width-1:0] CntOne = {{(cnt_width-1){1'b0}}, 1'b1};

  cdr_seq_state_t        state_q, state_d;
  logic [cnt_width-1:0]  dwell_q, dwell_d;
  logic [cnt_width-1:0]  dwell_t, dwell_lim;
  logic                  dwell_done;
  logic [prop_width-1:0] kp_q, kp_d;
  logic [intg_width-1:0] ki_q, ki_d;
  logic                  en_ext_q, en_ext_d;
  logic                  en_freq_q, en_freq_d;
  logic                  locked_q, locked_d;
  logic                  lock_lost_q, lock_lost_d;
  logic                  lock_hit, lock_miss, lock_clr;

  mm_cdr_seq_ctrl_lock_det #(
    .Nadc      (Nadc),
    .cnt_width (cnt_width)
  ) u_lock_det (
    .clk         (clk),
    .ext_rstb    (ext_rstb),
    .clr         (lock_clr),
    .phase_error (phase_error),
    .lock_thresh (lock_thresh),
    .lock_len    (lock_len),
    .lock_hit    (lock_hit),
    .lock_miss   (lock_miss)
  );

  always_comb begin
    dwell_t = '0;
    case (state_q)
      EXT_HOLD: dwell_t = t_ext;
      PROP_ACQ: dwell_t = t_prop;
      FREQ_ACQ: dwell_t = t_freq;
      default:  dwell_t = '0;
    endcase
  end

  // A dwell of 0 behaves as 1: leave after the first cycle in the state.
  assign dwell_lim  = (dwell_t == '0) ? '0 : dwell_t - CntOne;
  assign dwell_done = dwell_q >= dwell_lim;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = EXT_HOLD;
      EXT_HOLD: if (dwell_done) state_d = PROP_ACQ;
      PROP_ACQ: if (dwell_done) state_d = FREQ_ACQ;
      FREQ_ACQ: if (dwell_done) state_d = TRACK;
      TRACK:    if (lock_hit) state_d = LOCKED;
      LOCKED:   if (lock_miss) state_d = FREQ_ACQ;
      default:  state_d = IDLE;
    endcase
    if (!start) begin
      state_d = IDLE;
    end
  end

  assign lock_clr = (state_d != state_q) && use_trk_gains(state_d);

  // Outputs are registered from the next state so they line up with seq_state.
  always_comb begin
    dwell_d     = (state_d != state_q) ? '0 :
                  (dwell_q == '1)      ? dwell_q : dwell_q + CntOne;
    kp_d        = use_trk_gains(state_d) ? kp_trk : kp_acq;
    ki_d        = use_trk_gains(state_d) ? ki_trk : ki_acq;
    en_ext_d    = ext_pi_ctl_on(state_d);
    en_freq_d   = freq_est_on(state_d);
    locked_d    = (state_d == LOCKED);
    lock_lost_d = start && (state_q == LOCKED) && lock_miss;
  end

  always_ff @(posedge clk or negedge ext_rstb) begin
    if (!ext_rstb) begin
      state_q     <= IDLE;
      dwell_q     <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      en_ext_q    <= 1'b1;
      en_freq_q   <= 1'b0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      en_ext_q    <= en_ext_d;
      en_freq_q   <= en_freq_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign Kp            = kp_q;
  assign Ki            = ki_q;
  assign en_ext_pi_ctl = en_ext_q;
  assign en_freq_est   = en_freq_q;
  assign locked        = locked_q;
  assign lock_lost     = lock_lost_q;
  assign seq_state     = state_q;

endmodule

// File: tb/tb_mm_cdr_seq_ctrl.sv
// Bench for mm_cdr_seq_ctrl: directed sequences plus randomized stimulus, checked every cycle
// against a behavioural model built from cycle counts and run lengths.
module tb_mm_cdr_seq_ctrl;
  import mm_cdr_seq_ctrl_pkg::*;

  localparam int Nadc = 8;
  localparam int PW   = 6;
  localparam int IW   = 6;
  localparam int CW   = 16;

  logic                   clk = 1'b0;
  logic                   ext_rstb = 1'b1;
  logic                   start = 1'b0;
  logic signed [Nadc+1:0] phase_error = '0;
  logic [PW-1:0]          kp_acq = 6'd5, kp_trk = 6'd2;
  logic [IW-1:0]          ki_acq = 6'd6, ki_trk = 6'd3;
  logic [CW-1:0]          t_ext = 16'd4, t_prop = 16'd8, t_freq = 16'd16;
  logic [Nadc:0]          lock_thresh = 9'd8;
  logic [CW-1:0]          lock_len = 16'd10;
  logic [PW-1:0]          Kp;
  logic [IW-1:0]          Ki;
  logic                   en_ext_pi_ctl, en_freq_est, locked, lock_lost;
  logic [2:0]             seq_state;

  always #5 clk = ~clk;

  mm_cdr_seq_ctrl #(
    .Nadc       (Nadc),
    .prop_width (PW),
    .intg_width (IW),
    .cnt_width  (CW)
  ) dut (
    .clk           (clk),
    .ext_rstb      (ext_rstb),
    .start         (start),
    .phase_error   (phase_error),
    .kp_acq        (kp_acq),
    .kp_trk        (kp_trk),
    .ki_acq        (ki_acq),
    .ki_trk        (ki_trk),
    .t_ext         (t_ext),
    .t_prop        (t_prop),
    .t_freq        (t_freq),
    .lock_thresh   (lock_thresh),
    .lock_len      (lock_len),
    .Kp            (Kp),
    .Ki            (Ki),
    .en_ext_pi_ctl (en_ext_pi_ctl),
    .en_freq_est   (en_freq_est),
    .locked        (locked),
    .lock_lost     (lock_lost),
    .seq_state     (seq_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: cycles spent in the current state and current run lengths.
  cdr_seq_state_t m_state;
  int             m_time, m_in, m_out;
  logic [PW-1:0]  m_kp;
  logic [IW-1:0]  m_ki;
  bit             m_en_ext, m_en_freq, m_locked, m_lost;

  task automatic model_reset();
    m_state = IDLE;
    m_time = 0; m_in = 0; m_out = 0;
    m_kp = '0; m_ki = '0;
    m_en_ext = 1; m_en_freq = 0; m_locked = 0; m_lost = 0;
  endtask

  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic model_step();
    cdr_seq_state_t nxt;
    int  v, mag, len;
    bit  hit, lost;
    v    = int'(phase_error);
    mag  = (v < 0) ? -v : v;
    hit  = mag < int'(lock_thresh);
    len  = at_least_one(int'(lock_len));
    nxt  = m_state;
    lost = 0;
    case (m_state)
      IDLE:     nxt = EXT_HOLD;
      EXT_HOLD: if (m_time + 1 >= at_least_one(int'(t_ext)))  nxt = PROP_ACQ;
      PROP_ACQ: if (m_time + 1 >= at_least_one(int'(t_prop))) nxt = FREQ_ACQ;
      FREQ_ACQ: if (m_time + 1 >= at_least_one(int'(t_freq))) nxt = TRACK;
      TRACK:    if (hit && m_in + 1 >= len) nxt = LOCKED;
      LOCKED:   if (!hit && m_out + 1 >= len) begin nxt = FREQ_ACQ; lost = 1; end
      default:  nxt = IDLE;
    endcase
    if (!start) begin
      nxt = IDLE;
      lost = 0;
    end
    if (nxt != m_state && (nxt == TRACK || nxt == LOCKED)) begin
      m_in = 0; m_out = 0;
    end else if (hit) begin
      m_in++; m_out = 0;
    end else begin
      m_out++; m_in = 0;
    end
    m_time    = (nxt != m_state) ? 0 : m_time + 1;
    m_state   = nxt;
    m_lost    = lost;
    m_locked  = (nxt == LOCKED);
    m_en_ext  = (nxt == IDLE) || (nxt == EXT_HOLD);
    m_en_freq = (nxt == FREQ_ACQ) || (nxt == TRACK) || (nxt == LOCKED);
    m_kp      = (nxt == TRACK || nxt == LOCKED) ? kp_trk : kp_acq;
    m_ki      = (nxt == TRACK || nxt == LOCKED) ? ki_trk : ki_acq;
  endtask

  task automatic check_outputs();
    check("state", 32'(seq_state), 32'(m_state));
    check("ctl{ext,freq,locked,lost}", {28'd0, en_ext_pi_ctl, en_freq_est, locked, lock_lost},
          {28'd0, m_en_ext, m_en_freq, m_locked, m_lost});
    check("gains{Kp,Ki}", {20'd0, Kp, Ki}, {20'd0, m_kp, m_ki});
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic pulse_reset();
    ext_rstb = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    ext_rstb = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    ext_rstb = 1'b0;
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    ext_rstb = 1'b1;
    step();
    check("post_reset_kp", 32'(Kp), 32'd5);

    // Full acquisition sequence with nominal dwells.
    start = 1'b1;
    phase_error = '0;
    repeat (1 + 4) step();
    check("s1_prop_acq", 32'(seq_state), 32'(PROP_ACQ));
    check("s1_en_ext_low", 32'(en_ext_pi_ctl), 32'd0);
    repeat (8) step();
    check("s1_freq_acq", 32'(seq_state), 32'(FREQ_ACQ));
    check("s1_en_freq_high", 32'(en_freq_est), 32'd1);
    repeat (16) step();
    check("s1_track", 32'(seq_state), 32'(TRACK));

    // Interrupted in-lock run must not lock; a full run must.
    phase_error = 10'sd3;
    repeat (9) step();
    phase_error = -10'sd20;
    step();
    phase_error = -10'sd3;
    repeat (9) step();
    check("s2_not_yet_locked", 32'(locked), 32'd0);
    step();
    check("s2_locked", 32'(locked), 32'd1);
    check("s2_kp_trk", 32'(Kp), 32'd2);

    kp_trk = 6'd9;
    step();
    check("live_kp_trk", 32'(Kp), 32'd9);

    // Lock loss.
    phase_error = 10'sd50;
    repeat (9) step();
    step();
    check("s3_lock_lost", 32'(lock_lost), 32'd1);
    check("s3_freq_acq", 32'(seq_state), 32'(FREQ_ACQ));
    step();
    check("s3_lost_pulse_end", 32'(lock_lost), 32'd0);

    // Drop start in FREQ_ACQ.
    start = 1'b0;
    step();
    check("s6_idle_from_freq", 32'(seq_state), 32'(IDLE));

    // Zero dwells and zero lock_len.
    t_ext = '0; t_prop = '0; t_freq = '0; lock_len = '0;
    phase_error = '0;
    start = 1'b1;
    repeat (5) step();
    check("s4_locked_fast", 32'(seq_state), 32'(LOCKED));

    // Most-negative error is out of lock even at the largest threshold.
    lock_thresh = 9'h1FF;
    phase_error = 10'sh200;
    step();
    check("s5_lost_on_minneg", 32'(lock_lost), 32'd1);
    repeat (4) step();
    check("s5_stays_track", 32'(seq_state), 32'(TRACK));

    // Drop start in LOCKED: no lock_lost.
    phase_error = '0;
    step();
    start = 1'b0;
    step();
    check("s6_idle_from_locked", 32'(seq_state), 32'(IDLE));
    check("s6_no_lost", 32'(lock_lost), 32'd0);

    // Async reset in the middle of PROP_ACQ.
    t_ext = 16'd2; t_prop = 16'd8; t_freq = 16'd4; lock_len = 16'd3; lock_thresh = 9'd8;
    start = 1'b1;
    repeat (4) step();
    pulse_reset();
    check("s6_reset_idle", 32'(seq_state), 32'(IDLE));
    repeat (20) step();

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 149) == 0) begin
        t_ext       = CW'($urandom_range(0, 6));
        t_prop      = CW'($urandom_range(0, 6));
        t_freq      = CW'($urandom_range(0, 6));
        lock_len    = CW'($urandom_range(0, 5));
        lock_thresh = 9'($urandom_range(1, 60));
      end
      if ($urandom_range(0, 9) == 0) begin
        kp_acq = PW'($urandom); kp_trk = PW'($urandom);
        ki_acq = IW'($urandom); ki_trk = IW'($urandom);
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: phase_error = 10'($signed($urandom_range(0, 120)) - 60);
        9:             phase_error = 10'sh200;
        default:       phase_error = 10'($urandom);
      endcase
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
